// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with parallel load, wrap/saturate mode,
// terminal count and cascade carry. Digit i steps only when every lower digit is at its limit.
module bcd_updown_counter #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] d,
    output logic [4*DIGITS-1:0] q,
    output logic [4*DIGITS-1:0] qb,
    output logic                tc,
    output logic                co,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    // nine_chain[i] / zero_chain[i]: every digit below i is 9 / 0.
    logic [DIGITS:0]   nine_chain;
    logic [DIGITS:0]   zero_chain;
    logic [W-1:0]      step_q;
    logic [W-1:0]      load_q;
    logic [DIGITS-1:0] bad_digit;
    logic              sat_hold;

    assign nine_chain[0] = 1'b1;
    assign zero_chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] cur;
        logic [3:0] din;
        logic [3:0] nxt;

        assign cur = q[4*i +: 4];
        assign din = d[4*i +: 4];

        assign nine_chain[i+1] = nine_chain[i] & (cur == 4'd9);
        assign zero_chain[i+1] = zero_chain[i] & (cur == 4'd0);

        assign bad_digit[i]    = (din > 4'd9);
        assign load_q[4*i +: 4] = bad_digit[i] ? 4'd0 : din;

        // NOTE: nxt gets a default before any branch so no path leaves it unassigned (no latch).
        always_comb begin
            nxt = cur;
            if (up) begin
                if (nine_chain[i]) nxt = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
            end else begin
                if (zero_chain[i]) nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
            end
        end

        assign step_q[4*i +: 4] = nxt;
    end

    assign tc       = up ? nine_chain[DIGITS] : zero_chain[DIGITS];
    assign co       = tc & en & ~load;
    assign sat_hold = SATURATE & tc;
    assign qb       = ~q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            err <= 1'b0;
        end else if (load) begin
            q   <= load_q;
            err <= |bad_digit;
        end else if (en && !sat_hold) begin
            q   <= step_q;
        end
    end

endmodule
